// File: rtl/if_fetch.sv
// Instruction-fetch stage: byte-serial 4-byte fetch, IF/ID hand-off and IF stall request.
// Define ICACHE_EN to add a direct-mapped one-instruction-per-line I-cache.
module if_fetch #(
    parameter int ADDR_W       = 32,
    parameter int ICACHE_IDX_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [5:0]        stall_state,
    input  logic              ex_b_flag_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_byte_valid_i,
    input  logic [7:0]        mem_byte_i,
    output logic              if_valid_o,
    output logic [31:0]       if_inst_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic              stall_req_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt;
    logic [2:0][7:0]   byte_buf;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_done;
    logic              cache_hit;
    logic [31:0]       hit_inst;

    // Only the IF/ID stall bit matters to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall_state[5:2], stall_state[0]};

    assign stall_req_o = (state_q != IDLE);
    assign fetch_done  = (state_q == FETCH) && mem_byte_valid_i && (cnt == 2'd3) && !ex_b_flag_i;

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

    logic [LINES-1:0]        line_valid;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES];
    logic [ICACHE_IDX_W-1:0] idx_rd, idx_wr;
    logic [TAG_W-1:0]        tag_rd, tag_wr;

    assign idx_rd    = pc_i[ICACHE_IDX_W+1:2];
    assign tag_rd    = pc_i[ADDR_W-1:ICACHE_IDX_W+2];
    assign idx_wr    = fetch_pc[ICACHE_IDX_W+1:2];
    assign tag_wr    = fetch_pc[ADDR_W-1:ICACHE_IDX_W+2];
    assign cache_hit = line_valid[idx_rd] && (tag_mem[idx_rd] == tag_rd);
    assign hit_inst  = data_mem[idx_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
        end else if (rdy && fetch_done) begin
            line_valid[idx_wr] <= 1'b1;
        end
    end

    // NOTE: line storage has no reset; the valid bits alone make stale contents harmless.
    always_ff @(posedge clk) begin
        if (rdy && fetch_done) begin
            tag_mem[idx_wr]  <= tag_wr;
            data_mem[idx_wr] <= {mem_byte_i, byte_buf};
        end
    end
`else
    localparam int unused_idx_w = ICACHE_IDX_W;

    assign cache_hit = 1'b0;
    assign hit_inst  = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // NOTE: next state defaults to the current state so no path leaves state_d unassigned.
    always_comb begin
        state_d = state_q;
        if (ex_b_flag_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = cache_hit ? HOLD : FETCH;
                FETCH:   if (mem_byte_valid_i && cnt == 2'd3) state_d = HOLD;
                HOLD:    if (!stall_state[1]) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            byte_buf   <= '0;
            fetch_pc   <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            if_valid_o <= 1'b0;
            if_inst_o  <= '0;
            if_pc_o    <= '0;
        end else if (rdy) begin
            if (ex_b_flag_i) begin
                // A redirect drops whatever is in flight, including a word completing now.
                cnt        <= '0;
                mem_req_o  <= 1'b0;
                if_valid_o <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cache_hit) begin
                            if_inst_o  <= hit_inst;
                            if_pc_o    <= pc_i;
                            if_valid_o <= 1'b1;
                        end else begin
                            fetch_pc   <= pc_i;
                            mem_addr_o <= pc_i;
                            mem_req_o  <= 1'b1;
                            cnt        <= '0;
                        end
                    end
                    FETCH: begin
                        if (mem_byte_valid_i) begin
                            if (cnt == 2'd3) begin
                                mem_req_o  <= 1'b0;
                                if_inst_o  <= {mem_byte_i, byte_buf};
                                if_pc_o    <= fetch_pc;
                                if_valid_o <= 1'b1;
                            end else begin
                                byte_buf[cnt] <= mem_byte_i;
                            end
                            cnt <= cnt + 2'd1;
                        end
                    end
                    HOLD: begin
                        if (!stall_state[1]) begin
                            if_valid_o <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: vector table, directed corner cases and randomized transactions.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst, rdy, ex_b_flag_i, mem_byte_valid_i;
    logic [31:0] pc_i;
    logic [5:0]  stall_state;
    logic [7:0]  mem_byte_i;
    logic        mem_req_o, if_valid_o, stall_req_o;
    logic [31:0] mem_addr_o, if_inst_o, if_pc_o;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch #(.ADDR_W(32), .ICACHE_IDX_W(7)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .pc_i             (pc_i),
        .stall_state      (stall_state),
        .ex_b_flag_i      (ex_b_flag_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_byte_valid_i (mem_byte_valid_i),
        .mem_byte_i       (mem_byte_i),
        .if_valid_o       (if_valid_o),
        .if_inst_o        (if_inst_o),
        .if_pc_o          (if_pc_o),
        .stall_req_o      (stall_req_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        bv;
        logic [7:0]  b;
        logic [31:0] pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_sreq;
    } vec_t;

    function automatic vec_t mk(logic bv, logic [7:0] b, logic [31:0] pc, logic e_req,
                                logic [31:0] e_addr, logic e_valid, logic [31:0] e_inst,
                                logic [31:0] e_pc, logic e_sreq);
        vec_t v;
        v.bv = bv; v.b = b; v.pc = pc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc; v.e_sreq = e_sreq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic byte_cycle(input logic [7:0] b);
        mem_byte_valid_i = 1'b1;
        mem_byte_i       = b;
        step();
        mem_byte_valid_i = 1'b0;
    endtask

    // One full instruction: launch, 4 bytes with random gaps, hold, release.
    task automatic xact(input logic [31:0] pc, input logic [31:0] word, input int max_gap,
                        input int hold_cycles);
        pc_i             = pc;
        rdy              = 1'b1;
        stall_state      = 6'h0;
        mem_byte_valid_i = 1'($urandom_range(0, 1));
        mem_byte_i       = 8'($urandom);
        step();
        check("launch_req", {31'b0, mem_req_o}, 32'd1);
        check("launch_addr", mem_addr_o, pc);
        check("launch_sreq", {31'b0, stall_req_o}, 32'd1);
        check("launch_valid", {31'b0, if_valid_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            int gaps;
            gaps = $urandom_range(0, max_gap);
            for (int g = 0; g < gaps; g++) begin
                rdy              = 1'($urandom_range(0, 1));
                mem_byte_valid_i = !rdy;
                mem_byte_i       = 8'($urandom);
                pc_i             = $urandom;
                step();
                check("gap_valid", {31'b0, if_valid_o}, 32'd0);
                check("gap_sreq", {31'b0, stall_req_o}, 32'd1);
                check("gap_req", {31'b0, mem_req_o}, 32'd1);
            end
            rdy = 1'b1;
            byte_cycle(word[8*k +: 8]);
            if (k < 3) begin
                check("byte_valid", {31'b0, if_valid_o}, 32'd0);
            end else begin
                check("done_valid", {31'b0, if_valid_o}, 32'd1);
                check("done_inst", if_inst_o, word);
                check("done_pc", if_pc_o, pc);
                check("done_req", {31'b0, mem_req_o}, 32'd0);
            end
        end
        stall_state = 6'h2;
        for (int h = 0; h < hold_cycles; h++) begin
            mem_byte_valid_i = 1'($urandom_range(0, 1));
            mem_byte_i       = 8'($urandom);
            step();
            check("hold_valid", {31'b0, if_valid_o}, 32'd1);
            check("hold_inst", if_inst_o, word);
            check("hold_pc", if_pc_o, pc);
            check("hold_sreq", {31'b0, stall_req_o}, 32'd1);
        end
        stall_state      = 6'h0;
        mem_byte_valid_i = 1'b0;
        step();
        check("release_valid", {31'b0, if_valid_o}, 32'd0);
        check("release_sreq", {31'b0, stall_req_o}, 32'd0);
    endtask

    vec_t vecs [15];

    initial begin
        vecs[0]  = mk(0, 8'h00, 32'h0,  1, 32'h0,  0, 32'h0,        32'h0,  1);
        vecs[1]  = mk(1, 8'h13, 32'h4,  1, 32'h0,  0, 32'h0,        32'h0,  1);
        vecs[2]  = mk(1, 8'h05, 32'h4,  1, 32'h0,  0, 32'h0,        32'h0,  1);
        vecs[3]  = mk(1, 8'h10, 32'h4,  1, 32'h0,  0, 32'h0,        32'h0,  1);
        vecs[4]  = mk(1, 8'h00, 32'h4,  0, 32'h0,  1, 32'h00100513, 32'h0,  1);
        vecs[5]  = mk(0, 8'h00, 32'h10, 0, 32'h0,  0, 32'h0,        32'h0,  0);
        vecs[6]  = mk(0, 8'h00, 32'h10, 1, 32'h10, 0, 32'h0,        32'h0,  1);
        vecs[7]  = mk(1, 8'h13, 32'h14, 1, 32'h10, 0, 32'h0,        32'h0,  1);
        vecs[8]  = mk(0, 8'h00, 32'h14, 1, 32'h10, 0, 32'h0,        32'h0,  1);
        vecs[9]  = mk(1, 8'h05, 32'h14, 1, 32'h10, 0, 32'h0,        32'h0,  1);
        vecs[10] = mk(0, 8'h00, 32'h14, 1, 32'h10, 0, 32'h0,        32'h0,  1);
        vecs[11] = mk(1, 8'h10, 32'h14, 1, 32'h10, 0, 32'h0,        32'h0,  1);
        vecs[12] = mk(0, 8'h00, 32'h14, 1, 32'h10, 0, 32'h0,        32'h0,  1);
        vecs[13] = mk(1, 8'h00, 32'h14, 0, 32'h10, 1, 32'h00100513, 32'h10, 1);
        vecs[14] = mk(0, 8'h00, 32'h14, 0, 32'h10, 0, 32'h0,        32'h0,  0);

        rst = 1'b1; rdy = 1'b1; pc_i = 32'h0; stall_state = 6'h0;
        ex_b_flag_i = 1'b0; mem_byte_valid_i = 1'b0; mem_byte_i = 8'h0;
        step();
        step();
        check("rst_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_valid", {31'b0, if_valid_o}, 32'd0);
        check("rst_inst", if_inst_o, 32'h0);
        check("rst_pc", if_pc_o, 32'h0);
        check("rst_sreq", {31'b0, stall_req_o}, 32'd0);
        rst = 1'b0;

        // Back-to-back bytes, then the same word with one-cycle gaps.
        for (int i = 0; i < 15; i++) begin
            pc_i             = vecs[i].pc;
            mem_byte_valid_i = vecs[i].bv;
            mem_byte_i       = vecs[i].b;
            step();
            check($sformatf("vec%0d_req", i), {31'b0, mem_req_o}, {31'b0, vecs[i].e_req});
            check($sformatf("vec%0d_addr", i), mem_addr_o, vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i), {31'b0, if_valid_o}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d_sreq", i), {31'b0, stall_req_o}, {31'b0, vecs[i].e_sreq});
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_inst", i), if_inst_o, vecs[i].e_inst);
                check($sformatf("vec%0d_pc", i), if_pc_o, vecs[i].e_pc);
            end
        end
        mem_byte_valid_i = 1'b0;

        // Three cycles of IF/ID stall while holding.
        xact(32'h20, 32'hDEADBEEF, 0, 3);

        // Redirect after two bytes of the fetch at 0x4.
        pc_i = 32'h4;
        step();
        check("fl_launch_addr", mem_addr_o, 32'h4);
        byte_cycle(8'h78);
        byte_cycle(8'h56);
        ex_b_flag_i = 1'b1;
        pc_i        = 32'h100;
        step();
        check("fl_req", {31'b0, mem_req_o}, 32'd0);
        check("fl_valid", {31'b0, if_valid_o}, 32'd0);
        check("fl_sreq", {31'b0, stall_req_o}, 32'd0);
        ex_b_flag_i = 1'b0;
        byte_cycle(8'hAA);
        check("fl_relaunch_req", {31'b0, mem_req_o}, 32'd1);
        check("fl_relaunch_addr", mem_addr_o, 32'h100);
        check("fl_relaunch_valid", {31'b0, if_valid_o}, 32'd0);
        byte_cycle(8'h78);
        byte_cycle(8'h56);
        byte_cycle(8'h34);
        byte_cycle(8'h12);
        check("fl_tgt_valid", {31'b0, if_valid_o}, 32'd1);
        check("fl_tgt_inst", if_inst_o, 32'h12345678);
        check("fl_tgt_pc", if_pc_o, 32'h100);
        step();

        // Redirect in the same cycle as the final byte wins.
        pc_i = 32'h40;
        step();
        byte_cycle(8'h01);
        byte_cycle(8'h02);
        byte_cycle(8'h03);
        ex_b_flag_i = 1'b1;
        byte_cycle(8'h04);
        ex_b_flag_i = 1'b0;
        check("flc_valid", {31'b0, if_valid_o}, 32'd0);
        check("flc_req", {31'b0, mem_req_o}, 32'd0);
        check("flc_sreq", {31'b0, stall_req_o}, 32'd0);

        // Reset in the middle of a fetch.
        pc_i = 32'h200;
        step();
        byte_cycle(8'h01);
        byte_cycle(8'h02);
        rst = 1'b1;
        byte_cycle(8'h03);
        rst = 1'b0;
        check("mrst_req", {31'b0, mem_req_o}, 32'd0);
        check("mrst_addr", mem_addr_o, 32'h0);
        check("mrst_valid", {31'b0, if_valid_o}, 32'd0);
        check("mrst_inst", if_inst_o, 32'h0);
        check("mrst_pc", if_pc_o, 32'h0);
        check("mrst_sreq", {31'b0, stall_req_o}, 32'd0);

        // rdy low for five cycles mid-fetch freezes everything.
        pc_i = 32'h300;
        byte_cycle(8'hEE);
        check("rdy_launch_addr", mem_addr_o, 32'h300);
        byte_cycle(8'h11);
        byte_cycle(8'h22);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc_i = $urandom;
            byte_cycle(8'($urandom));
            check("frz_req", {31'b0, mem_req_o}, 32'd1);
            check("frz_addr", mem_addr_o, 32'h300);
            check("frz_valid", {31'b0, if_valid_o}, 32'd0);
            check("frz_sreq", {31'b0, stall_req_o}, 32'd1);
        end
        rdy = 1'b1;
        byte_cycle(8'h33);
        check("frz_b3_valid", {31'b0, if_valid_o}, 32'd0);
        byte_cycle(8'h44);
        check("frz_done_valid", {31'b0, if_valid_o}, 32'd1);
        check("frz_done_inst", if_inst_o, 32'h44332211);
        check("frz_done_pc", if_pc_o, 32'h300);
        step();
        check("frz_release_sreq", {31'b0, stall_req_o}, 32'd0);

        // Randomized transactions, starting at the top of the address space.
        xact(32'hFFFF_FFFC, $urandom, 2, 1);
        for (int t = 0; t < 30; t++) begin
            xact({$urandom_range(1, 32'h3FFF_FFFF), 2'b00} | 32'h8000_0000, $urandom, 2,
                 $urandom_range(0, 3));
        end

`ifdef ICACHE_EN
        xact(32'h8, 32'hCAFEF00D, 0, 0);
        pc_i = 32'h8;
        step();
        check("ic_hit_req", {31'b0, mem_req_o}, 32'd0);
        check("ic_hit_valid", {31'b0, if_valid_o}, 32'd1);
        check("ic_hit_inst", if_inst_o, 32'hCAFEF00D);
        check("ic_hit_pc", if_pc_o, 32'h8);
        check("ic_hit_sreq", {31'b0, stall_req_o}, 32'd1);
        step();
        check("ic_hit_release", {31'b0, if_valid_o}, 32'd0);
        xact(32'h40, 32'h0BADC0DE, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
